// File: rtl/freq_meter_pkg.sv
// Shared types and sizing helpers for the frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  // Gate counter only has to reach GATE_CYCLES-1; keep at least one bit.
  function automatic int gate_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous input and flags its rising edges as one-cycle pulses.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic async_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   history;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q  <= '0;
      history <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      history <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_out = sync_q[SYNC_STAGES-1] & ~history;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a window of GATE_CYCLES clk_in cycles.
// Handshake: meas_valid is a one-cycle pulse with no ready; meas_count/overflow are stable from that pulse until the next one.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             continuous,
  input  logic             sig_in,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             overflow,
  output logic             busy,
  output state_t           state
);

  localparam int               GW        = gate_w(GATE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(cnt_max(CNT_W));
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);

  state_t           next_state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_cnt_nxt;
  logic             ovf;
  logic             ovf_nxt;
  logic             edge_det;
  logic             gate_last;
  logic             arm;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk_in  (clk_in),
    .reset   (reset),
    .async_in(sig_in),
    .edge_out(edge_det)
  );

  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  assign gate_last = (gate_cnt == GATE_LAST);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = GATE;
      GATE: begin
        if (!enable)        next_state = IDLE;
        else if (gate_last) next_state = DONE;
      end
      DONE:    next_state = (enable && continuous) ? GATE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    meas_valid = (state == DONE);
    busy       = (state == GATE) || (state == DONE);
  end

  // Entering GATE from IDLE or DONE starts a fresh window.
  assign arm = (next_state == GATE) && (state != GATE);

  // Saturating count; an edge that would wrap marks the window as overflowed.
  always_comb begin
    edge_cnt_nxt = edge_cnt;
    ovf_nxt      = ovf;
    if (edge_det) begin
      if (edge_cnt == CNT_MAX) ovf_nxt = 1'b1;
      else                     edge_cnt_nxt = edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf        <= 1'b0;
      meas_count <= '0;
      overflow   <= 1'b0;
    end else if (arm) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else if (state == GATE && enable) begin
      gate_cnt <= gate_cnt + GW'(1);
      edge_cnt <= edge_cnt_nxt;
      ovf      <= ovf_nxt;
      if (gate_last) begin
        meas_count <= edge_cnt_nxt;
        overflow   <= ovf_nxt;
      end
    end
  end

endmodule
